// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared types and constants for the 4:1 mux select sequencer
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam int NUM_CH    = 4;
  localparam int CH_W      = 2;
  localparam int DWELL_MAX = 255;

endpackage

// File: rtl/mux_scan_seq_if.sv
// rtl/mux_scan_seq_if.sv - control/status bundle between the scan sequencer and its user
interface mux_scan_seq_if;
  import mux_scan_pkg::*;

  logic              start;
  logic [NUM_CH-1:0] en_mask;
  logic              y;
  logic              s1;
  logic              s0;
  logic              busy;
  logic              done;
  logic [NUM_CH-1:0] result;

  modport master (
    output start,
    output en_mask,
    output y,
    input  s1,
    input  s0,
    input  busy,
    input  done,
    input  result
  );

  modport slave (
    input  start,
    input  en_mask,
    input  y,
    output s1,
    output s0,
    output busy,
    output done,
    output result
  );

endinterface

// File: rtl/mux_scan_next_ch.sv
// rtl/mux_scan_next_ch.sv - finds the next higher enabled channel above cur (or the lowest when first)
module mux_scan_next_ch
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur,
  input  logic              first,
  output logic [CH_W-1:0]   nxt,
  output logic              found
);

  // Walk downwards so the lowest qualifying channel is the one left standing.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (first || (i > int'(cur)))) begin
        nxt   = CH_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_seq.sv
// rtl/mux_scan_seq.sv - steps s1:s0 through enabled mux channels, samples y after a dwell, pulses done
module mux_scan_seq
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 2
) (
  input logic           clk,
  input logic           rst,
  mux_scan_seq_if.slave bus
);

  localparam int              CNT_W    = ($clog2(DWELL + 1) < 1) ? 1 : $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] result_q, result_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              idle;
  logic [NUM_CH-1:0] lookup_mask;
  logic [CH_W-1:0]   nxt_ch;
  logic              nxt_found;

  // In IDLE the lookup serves the start request, otherwise it advances past the current channel.
  assign idle        = (state_q == IDLE);
  assign lookup_mask = idle ? bus.en_mask : mask_q;

  mux_scan_next_ch u_next_ch (
    .mask  (lookup_mask),
    .cur   (ch_q),
    .first (idle),
    .nxt   (nxt_ch),
    .found (nxt_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mask_q   <= '0;
      result_q <= '0;
      ch_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      result_q <= result_d;
      ch_q     <= ch_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    result_d = result_q;
    ch_d     = ch_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          result_d = '0;
          mask_d   = bus.en_mask;
          if (nxt_found) begin
            ch_d    = nxt_ch;
            cnt_d   = CNT_LOAD;
            busy_d  = 1'b1;
            state_d = SCAN;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end

      SCAN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          result_d[ch_q] = bus.y;
          if (nxt_found) begin
            ch_d  = nxt_ch;
            cnt_d = CNT_LOAD;
          end else begin
            ch_d    = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.s1     = ch_q[1];
  assign bus.s0     = ch_q[0];
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: doc/mux_scan_seq.md
Name: mux_scan_seq

Overview:
Upstream select sequencer for the 4:1 mux block (data a/b/c/d, selects s1/s0, output y). On a start request it steps s1:s0 through the enabled channels in ascending order and holds each select for a programmable dwell. After the dwell it samples the mux output y into a 4-bit result register, then reports completion with a one-cycle done pulse. It turns the combinational mux into a sampled 4-channel scanner for the consuming logic.

Parameters:
DWELL, 2, number of clk cycles each select value is held before y is sampled; legal range 1..255.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  scan request; sampled on rising clk edge
en_mask  input  4  channel enable; bit i = channel i (0=a, 1=b, 2=c, 3=d); latched when start is accepted
y  input  1  mux output; treated as synchronous to clk
s1  output  1  mux select MSB (registered)
s0  output  1  mux select LSB (registered)
busy  output  1  high while a scan is in progress
done  output  1  one-cycle pulse when a scan completes
result  output  4  sampled y per channel; bit i = channel i

Behaviour:
- Reset (async, asserted at any time, including mid-scan): s1=0, s0=0, busy=0, done=0, result=0, state=IDLE, dwell counter=0, latched mask=0. A scan in progress is abandoned and produces no done pulse.
- States: IDLE, SCAN, DONE.
- IDLE: s1:s0=00, busy=0.
  - start=1 and en_mask!=0: latch mask, clear result to 0, drive s1:s0 = lowest enabled channel, load counter with DWELL-1, busy=1, go to SCAN.
  - start=1 and en_mask==0: clear result, go to DONE. busy stays 0.
- SCAN: each edge with counter!=0 decrements the counter; select is held. On the edge where counter==0:
  - result[ch] <= y.
  - If a higher enabled channel exists, s1:s0 <= next enabled channel and counter <= DWELL-1; stay in SCAN.
  - Otherwise s1:s0 <= 00, busy <= 0, done <= 1, go to DONE.
- DONE: lasts exactly one cycle with done=1. Next edge: done <= 0, go to IDLE.
- Latency: with k enabled channels, if start is accepted at edge E, channel j (0-based in visit order) is sampled at edge E+(j+1)*DWELL. done is high in the cycle following edge E+k*DWELL. For k=0, done is high in the cycle following E.
- start is ignored while busy=1 or done=1. start in the first IDLE cycle after DONE is accepted, so back-to-back scans are allowed.
- en_mask changes during a scan have no effect; the latched copy is used.
- Result bits of disabled channels read 0. result holds its value until the next accepted start and is valid whenever done=1.
- Select outputs change only on clk edges and come straight from flops, so they are glitch-free.
- Counter width: $clog2(DWELL+1) bits, at least 1.

Decomposition:
- Package mux_scan_pkg:
  - state enum {IDLE, SCAN, DONE}
  - NUM_CH=4
  - CH_W=2
  - DWELL_MAX=255
- One combinational sub-module, mux_scan_next_ch: given the 4-bit mask and the current channel (or a "none yet" flag), it returns the next higher enabled channel index and a found flag. It serves both the lowest-enabled lookup on start and the advance on each sample.
- The FSM, counter and result register stay in mux_scan_seq.

Test Plan:
Bench uses the real 4:1 mux downstream with data inputs tied a=0, b=1, c=1, d=0, and DWELL=2.
1. rst pulsed high asynchronously between clk edges -> s1, s0, busy, done and result all read 0 immediately, with no clk edge needed.
2. start for one cycle with en_mask=4'b1111 -> s1:s0 = 00,01,10,11, each held 2 cycles; done high in cycle 8 after the start edge; result=4'b0110; busy low again in the same cycle as done.
3. en_mask=4'b1010 -> only 01 then 11 are driven; done high in cycle 4 after start; result=4'b0010.
4. en_mask=4'b0000 -> busy never rises; done pulses in the cycle after start; result=4'b0000; s1:s0 stays 00.
5. start re-asserted while busy, with a different mask, is ignored and the result matches the first mask. start held through DONE into IDLE is accepted, and the second scan's done arrives 8 cycles after that edge.
6. rst asserted 3 cycles into a full scan -> outputs return to reset values, no done appears afterwards, and a subsequent full-mask start completes normally with result=4'b0110.
